// File: rtl/exc_pkg.sv
// Shared types and widths for the exception unit.
package exc_pkg;
  localparam int ESR_W = 4;
  localparam int PC_W  = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    ACK     = 2'd2,
    HANDLER = 2'd3
  } exc_state_e;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt sequencer: synchronizes irq_in, tracks a pending interrupt,
// captures ELR/ESR on exception entry and flags nested exceptions.
//
// state   | meaning
// IDLE    | no interrupt pending, normal execution
// PEND    | interrupt pending, ExtIRQ raised to the controller
// ACK     | ELR/ESR just captured, ExcAck pulse
// HANDLER | handler running, interrupts masked
module exception_unit
  import exc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             irq_in,
  input  logic             Exc,
  input  logic             ExtIAck,
  input  logic             ERet,
  input  logic [ESR_W-1:0] EStatus,
  input  logic [PC_W-1:0]  pc_in,
  output logic             ExtIRQ,
  output logic             ExcAck,
  output logic [PC_W-1:0]  ELR,
  output logic [ESR_W-1:0] ESR,
  output logic             in_handler,
  output logic             dbl_fault
);
  exc_state_e state;
  logic       irq_sync;
  logic       irq_sync_q;
  logic       irq_rise;
  logic       irq_pend;
  logic       pend_next;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (reset),
    .d     (irq_in),
    .q     (irq_sync)
  );

  // irq_sync_q resets to 0, so a line already high at reset release reads as an edge.
  assign irq_rise  = irq_sync & ~irq_sync_q;
  assign pend_next = irq_rise | (irq_pend & ~((state == ACK) & ExtIAck));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      irq_sync_q <= 1'b0;
      irq_pend   <= 1'b0;
      ExtIRQ     <= 1'b0;
      ExcAck     <= 1'b0;
      ELR        <= '0;
      ESR        <= '0;
      in_handler <= 1'b0;
      dbl_fault  <= 1'b0;
    end else begin
      irq_sync_q <= irq_sync;
      irq_pend   <= pend_next;
      ExcAck     <= 1'b0;
      case (state)
        IDLE: begin
          if (Exc) begin
            state  <= ACK;
            ELR    <= pc_in;
            ESR    <= EStatus;
            ExcAck <= 1'b1;
            ExtIRQ <= 1'b0;
          end else if (pend_next) begin
            state  <= PEND;
            ExtIRQ <= 1'b1;
          end else begin
            ExtIRQ <= 1'b0;
          end
        end
        PEND: begin
          ExtIRQ <= 1'b1;
          if (Exc) begin
            state  <= ACK;
            ELR    <= pc_in;
            ESR    <= EStatus;
            ExcAck <= 1'b1;
          end
        end
        ACK: begin
          state      <= HANDLER;
          in_handler <= 1'b1;
          ExtIRQ     <= 1'b0;
        end
        HANDLER: begin
          if (Exc) dbl_fault <= 1'b1;
          if (ERet) begin
            in_handler <= 1'b0;
            if (pend_next) begin
              state  <= PEND;
              ExtIRQ <= 1'b1;
            end else begin
              state  <= IDLE;
              ExtIRQ <= 1'b0;
            end
          end else begin
            ExtIRQ <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit with an expected-output scoreboard queue.
module tb_exception_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        irq_in, Exc, ExtIAck, ERet;
  logic [3:0]  EStatus;
  logic [63:0] pc_in;
  logic        ExtIRQ, ExcAck, in_handler, dbl_fault;
  logic [63:0] ELR;
  logic [3:0]  ESR;

  typedef struct {
    string       tag;
    logic        extirq;
    logic        excack;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic        inh;
    logic        dbl;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  exception_unit dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .Exc        (Exc),
    .ExtIAck    (ExtIAck),
    .ERet       (ERet),
    .EStatus    (EStatus),
    .pc_in      (pc_in),
    .ExtIRQ     (ExtIRQ),
    .ExcAck     (ExcAck),
    .ELR        (ELR),
    .ESR        (ESR),
    .in_handler (in_handler),
    .dbl_fault  (dbl_fault)
  );

  task automatic cmp(input string tag, input string field, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic extirq, input logic excack,
                      input logic [63:0] elr, input logic [3:0] esr,
                      input logic inh, input logic dbl);
    exp_t e;
    e.tag = tag; e.extirq = extirq; e.excack = excack;
    e.elr = elr; e.esr = esr; e.inh = inh; e.dbl = dbl;
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      cmp(e.tag, "ExtIRQ",     {63'd0, ExtIRQ},     {63'd0, e.extirq});
      cmp(e.tag, "ExcAck",     {63'd0, ExcAck},     {63'd0, e.excack});
      cmp(e.tag, "ELR",        ELR,                 e.elr);
      cmp(e.tag, "ESR",        {60'd0, ESR},        {60'd0, e.esr});
      cmp(e.tag, "in_handler", {63'd0, in_handler}, {63'd0, e.inh});
      cmp(e.tag, "dbl_fault",  {63'd0, dbl_fault},  {63'd0, e.dbl});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_check();
    tick();
    check_now();
  endtask

  initial begin
    reset = 1'b0; irq_in = 1'b0; Exc = 1'b0; ExtIAck = 1'b0; ERet = 1'b0;
    EStatus = 4'h0; pc_in = 64'h0;
    #12;
    push("reset", 0, 0, 64'h0, 4'h0, 0, 0);
    check_now();
    tick();
    reset = 1'b1;

    // irq at cycle 0 -> ExtIRQ by cycle 3, then exception entry from PEND
    irq_in = 1'b1;
    tick(); tick();
    push("irq_latency", 1, 0, 64'h0, 4'h0, 0, 0);
    tick_check();
    irq_in = 1'b0;
    Exc = 1'b1; pc_in = 64'h40; EStatus = 4'h1;
    push("pend_capture", 1, 1, 64'h40, 4'h1, 0, 0);
    tick_check();
    Exc = 1'b0; ExtIAck = 1'b1;
    push("ack_to_handler", 0, 0, 64'h40, 4'h1, 1, 0);
    tick_check();
    ExtIAck = 1'b0; ERet = 1'b1;
    push("eret_to_idle", 0, 0, 64'h40, 4'h1, 0, 0);
    tick_check();

    // ERet in IDLE is ignored
    push("eret_idle", 0, 0, 64'h40, 4'h1, 0, 0);
    tick_check();
    ERet = 1'b0;

    // exception from IDLE
    Exc = 1'b1; pc_in = 64'h100; EStatus = 4'h2;
    push("idle_capture", 0, 1, 64'h100, 4'h2, 0, 0);
    tick_check();
    Exc = 1'b0;
    push("idle_handler", 0, 0, 64'h100, 4'h2, 1, 0);
    tick_check();

    // nested exception -> double fault, registers held
    Exc = 1'b1; pc_in = 64'h200; EStatus = 4'h7;
    push("dbl_fault", 0, 0, 64'h100, 4'h2, 1, 1);
    tick_check();
    Exc = 1'b0;

    // irq pulse while in HANDLER stays masked, ERet returns to PEND
    irq_in = 1'b1;
    push("hdl_irq_a", 0, 0, 64'h100, 4'h2, 1, 1);
    tick_check();
    irq_in = 1'b0;
    push("hdl_irq_b", 0, 0, 64'h100, 4'h2, 1, 1);
    tick_check();
    push("hdl_irq_c", 0, 0, 64'h100, 4'h2, 1, 1);
    tick_check();
    ERet = 1'b1;
    push("eret_to_pend", 1, 0, 64'h100, 4'h2, 0, 1);
    tick_check();
    ERet = 1'b0;

    // async reset in the middle of ACK
    Exc = 1'b1; pc_in = 64'h300; EStatus = 4'h3;
    push("pend_capture2", 1, 1, 64'h300, 4'h3, 0, 1);
    tick_check();
    Exc = 1'b0;
    #2 reset = 1'b0;
    #1;
    push("async_reset", 0, 0, 64'h0, 4'h0, 0, 0);
    check_now();
    #2 reset = 1'b1;
    push("post_reset", 0, 0, 64'h0, 4'h0, 0, 0);
    tick_check();

    // ERet and Exc together in HANDLER: ERet wins, dbl_fault set
    Exc = 1'b1; pc_in = 64'h500; EStatus = 4'h5;
    push("idle_capture3", 0, 1, 64'h500, 4'h5, 0, 0);
    tick_check();
    Exc = 1'b0;
    push("handler3", 0, 0, 64'h500, 4'h5, 1, 0);
    tick_check();
    Exc = 1'b1; ERet = 1'b1; pc_in = 64'h600; EStatus = 4'h6;
    push("eret_and_exc", 0, 0, 64'h500, 4'h5, 0, 1);
    tick_check();
    Exc = 1'b0; ERet = 1'b0;

    // irq_in already high at reset release counts as an edge
    #2 reset = 1'b0;
    irq_in = 1'b1;
    #2 reset = 1'b1;
    tick(); tick();
    push("irq_high_at_release", 1, 0, 64'h0, 4'h0, 0, 0);
    tick_check();

    // irq edge coinciding with ExtIAck keeps irq_pend set
    irq_in = 1'b0;
    push("pend_hold_a", 1, 0, 64'h0, 4'h0, 0, 0);
    tick_check();
    push("pend_hold_b", 1, 0, 64'h0, 4'h0, 0, 0);
    tick_check();
    irq_in = 1'b1;
    push("pend_hold_c", 1, 0, 64'h0, 4'h0, 0, 0);
    tick_check();
    Exc = 1'b1; pc_in = 64'h700; EStatus = 4'h9;
    push("pend_capture4", 1, 1, 64'h700, 4'h9, 0, 0);
    tick_check();
    Exc = 1'b0; ExtIAck = 1'b1;
    push("ack_with_edge", 0, 0, 64'h700, 4'h9, 1, 0);
    tick_check();
    ExtIAck = 1'b0; ERet = 1'b1;
    push("edge_beats_ack", 1, 0, 64'h700, 4'h9, 0, 0);
    tick_check();
    ERet = 1'b0;

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; every other port SHALL be synchronous to clk.
REQ-002 clk  in  1  processor clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 irq_in  in  1  raw external interrupt line, asynchronous to clk, level-high.
REQ-005 Exc  in  1  exception taken this cycle, from the controller (ExtIRQ or NotAnInstr).
REQ-006 ExtIAck  in  1  interrupt acknowledge from the controller.
REQ-007 ERet  in  1  exception-return instruction executing this cycle.
REQ-008 EStatus  in  4  exception cause code from the controller.
REQ-009 pc_in  in  64  PC of the instruction executing this cycle.
REQ-010 ExtIRQ  out  1  interrupt request to the controller.
REQ-011 ExcAck  out  1  one-cycle pulse: ELR/ESR captured.
REQ-012 ELR  out  64  exception link register (return PC).
REQ-013 ESR  out  4  exception syndrome register (captured cause).
REQ-014 in_handler  out  1  high while the handler runs; nesting is not allowed.
REQ-015 dbl_fault  out  1  sticky flag: Exc seen while in_handler.

Function
REQ-016 irq_in SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL set irq_pend.
REQ-017 The FSM SHALL have the states IDLE, PEND, ACK and HANDLER.
REQ-018 IDLE: irq_pend=1 -> PEND next cycle; Exc=1 -> capture per REQ-020, then ACK; Exc takes priority over irq_pend.
REQ-019 PEND: ExtIRQ=1; Exc=1 -> capture, then ACK; otherwise stay in PEND.
REQ-020 Capture SHALL set ELR<=pc_in and ESR<=EStatus on the same clock edge as the state change.
REQ-021 ACK: ExcAck=1 for exactly one cycle; ExtIRQ stays 1 in ACK if it was 1 in PEND; ExtIAck=1 clears irq_pend; next state is always HANDLER.
REQ-022 HANDLER: in_handler=1 and ExtIRQ=0 (masked); new irq edges set irq_pend without leaving HANDLER.
REQ-023 HANDLER with ERet=1: next state is PEND if irq_pend=1, otherwise IDLE; ELR and ESR hold their values.
REQ-024 HANDLER with Exc=1: set dbl_fault; ELR and ESR unchanged; no ExcAck.
REQ-025 HANDLER with ERet=1 and Exc=1 in the same cycle: ERet wins and dbl_fault is set.
REQ-026 An irq edge and ExtIAck in the same cycle: set has priority, so irq_pend stays 1.
REQ-027 ERet outside HANDLER SHALL be ignored.
REQ-028 ExtIRQ SHALL be a registered output (decoded from state and irq_pend); no combinational path from Exc or ExtIAck to ExtIRQ or ExcAck.
REQ-029 Latency: irq_in rise to ExtIRQ=1 SHALL be at most 3 cycles.

Reset
REQ-030 reset=0 SHALL asynchronously force: state=IDLE, synchronizer=0, irq_pend=0, ExtIRQ=0, ExcAck=0, ELR=0, ESR=0, in_handler=0, dbl_fault=0.
REQ-031 Reset during PEND, ACK or HANDLER SHALL discard any pending interrupt and the captured ELR/ESR.
REQ-032 After reset is released, an irq_in level that is already high SHALL count as a rising edge.

Structure
REQ-033 The state enum, the ESR width (4) and the PC width (64) SHALL live in the shared package exc_pkg.
REQ-034 The synchronizer SHALL be a separate sub-module, sync2.

Verification
REQ-035 irq_in=1 at cycle 0 -> ExtIRQ=1 by cycle 3; Exc=1 with pc_in=0x40, EStatus=0x1 -> next cycle ExcAck=1, ELR=0x40, ESR=0x1; ExtIAck=1 -> HANDLER, ExtIRQ=0.
REQ-036 IDLE, Exc=1 with pc_in=0x100, EStatus=0x2, ExtIRQ=0 -> ELR=0x100, ESR=0x2, one ExcAck pulse, then in_handler=1.
REQ-037 In HANDLER, irq_in pulses, then ERet=1 -> state PEND, ExtIRQ=1 the following cycle.
REQ-038 In HANDLER, Exc=1 with pc_in=0x200 -> dbl_fault=1, ELR unchanged, ExcAck=0.
REQ-039 reset=0 asserted mid-ACK, asynchronous to clk -> all outputs 0 immediately, before the next clock edge.
REQ-040 ERet=1 while IDLE -> no state change and no output change.
